// File: rtl/posit_ext_op_sequencer_if.sv
// Request/response bundle for posit_ext_op_sequencer.
//   slave  : the sequencer (consumes requests, produces results)
//   master : the requester/consumer driving it
// Signals:
//   in_valid_i/in_ready_o   request handshake
//   in_op_i                 00 NEG, 01 ABS, 10 SGN, 11 RNI
//   in_operand_i, in_tag_i  posit operand and pass-through tag
//   out_valid_o/out_ready_i result handshake
//   out_result_o, out_tag_o, out_nar_o  result word, its tag, NaR flag
//   busy_o                  sequencer has work in flight or a pending result
interface posit_ext_op_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       in_op_i;
  logic [WIDTH-1:0] in_operand_i;
  logic [TAG_W-1:0] in_tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_result_o;
  logic [TAG_W-1:0] out_tag_o;
  logic             out_nar_o;
  logic             busy_o;

  modport slave (
    input  in_valid_i, in_op_i, in_operand_i, in_tag_i, out_ready_i,
    output in_ready_o, out_valid_o, out_result_o, out_tag_o, out_nar_o, busy_o
  );

  modport master (
    output in_valid_i, in_op_i, in_operand_i, in_tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_result_o, out_tag_o, out_nar_o, busy_o
  );
endinterface

// File: rtl/posit_ext_op_sequencer.sv
// Sequencer for the posit FPU's extended ops (NEG, ABS, SGN, RNI).
// NEG/ABS/SGN complete on the accept edge; RNI runs DECODE -> ROUND -> ENCODE
// and waits in HOLD if the single output register is still occupied.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    posit_ext_op_sequencer_if.slave (request/result handshakes, busy)
module posit_ext_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int ES    = 1,
  parameter int TAG_W = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  posit_ext_op_sequencer_if.slave bus
);
  localparam logic [WIDTH-1:0] NAR     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {2'b01, {(WIDTH-2){1'b0}}};
  localparam logic [WIDTH-1:0] NEG_ONE = {2'b11, {(WIDTH-2){1'b0}}};
  // At or above this scale no fraction bits survive: operand is already integral.
  localparam int SBYP = WIDTH - ES - 3;
  localparam logic [1:0] OP_NEG = 2'b00, OP_ABS = 2'b01, OP_RNI = 2'b11;
  localparam logic [1:0] M_CALC = 2'd0, M_PASS = 2'd1, M_ZERO = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_ROUND, S_ENCODE, S_HOLD} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opnd, r_sig, r_n;
  logic [TAG_W-1:0] r_tag;
  logic             r_sign;
  logic [1:0]       r_mode;
  int               r_scale;
  logic             r_out_valid, r_out_nar;
  logic [WIDTH-1:0] r_out_result;
  logic [TAG_W-1:0] r_out_tag;

  logic             w_free, w_accept, w_load;
  logic [WIDTH-1:0] w_neg, w_sc_res, w_rni_res, w_load_res;
  logic [TAG_W-1:0] w_load_tag;

  assign w_free   = !r_out_valid | bus.out_ready_i;
  assign w_accept = bus.in_valid_i & (r_state == S_IDLE) & w_free;

  // Single-cycle ops
  assign w_neg = -bus.in_operand_i;
  always_comb begin
    w_sc_res = w_neg;
    case (bus.in_op_i)
      OP_NEG: w_sc_res = w_neg;
      OP_ABS: w_sc_res = bus.in_operand_i[WIDTH-1] ? w_neg : bus.in_operand_i;
      default:
        if (bus.in_operand_i == '0 || bus.in_operand_i == NAR) w_sc_res = bus.in_operand_i;
        else w_sc_res = bus.in_operand_i[WIDTH-1] ? NEG_ONE : ONE;
    endcase
  end

  // DECODE: magnitude -> regime run, exponent, left-aligned fraction
  logic [WIDTH-1:0] w_mag;
  logic [WIDTH-2:0] w_body, w_frac;
  int               w_run, w_k, w_exp, w_scale;
  logic             w_done;
  always_comb begin
    w_mag  = r_opnd[WIDTH-1] ? -r_opnd : r_opnd;
    w_run  = 0;
    w_done = 1'b0;
    for (int i = WIDTH-2; i >= 0; i--) begin
      if (!w_done) begin
        if (w_mag[i] == w_mag[WIDTH-2]) w_run = w_run + 1;
        else w_done = 1'b1;
      end
    end
    w_k     = w_mag[WIDTH-2] ? w_run - 1 : -w_run;
    // drop regime run and its terminator
    w_body  = w_mag[WIDTH-2:0] << (w_run + 1);
    w_exp   = int'(w_body >> (WIDTH-1-ES));
    w_frac  = w_body << ES;
    w_scale = w_k * (1 << ES) + w_exp;
  end

  // ROUND: place 1.frac with its integer bit at position WIDTH+scale, then RNE
  logic [2*WIDTH-1:0] w_fx;
  logic [WIDTH-1:0]   w_int, w_n;
  logic               w_rup;
  always_comb begin
    w_fx  = {{WIDTH{1'b0}}, r_sig} << (r_scale + 1);
    w_int = w_fx[2*WIDTH-1:WIDTH];
    w_rup = w_fx[WIDTH-1] & ((|w_fx[WIDTH-2:0]) | w_int[0]);
    w_n   = w_int + {{(WIDTH-1){1'b0}}, w_rup};
  end

  // ENCODE: build {regime, exponent, fraction} stream, truncate with RNE
  int                 w_p, w_kk, w_ee;
  logic [WIDTH-1:0]   w_frac_al, w_reg, w_enc;
  logic [3*WIDTH-1:0] w_ef, w_str;
  logic [WIDTH-2:0]   w_pbody;
  logic               w_erup;
  always_comb begin
    w_p = 0;
    for (int i = 0; i < WIDTH; i++) if (r_n[i]) w_p = i;
    w_kk      = w_p >> ES;
    w_ee      = w_p & ((1 << ES) - 1);
    w_frac_al = r_n << (WIDTH - w_p);            // hidden bit shifted out
    w_reg     = ~({WIDTH{1'b1}} >> (w_kk + 1));  // kk+1 ones, then the terminator 0
    w_ef      = {{(2*WIDTH){1'b0}}, w_frac_al} | ((3*WIDTH)'(w_ee) << WIDTH);
    w_str     = {w_reg, {(2*WIDTH){1'b0}}} | (w_ef << (2*WIDTH - w_kk - 2 - ES));
    w_pbody   = w_str[3*WIDTH-1 -: WIDTH-1];
    // all-ones body is maxpos: rounding up would wrap into NaR, so saturate
    w_erup    = w_str[2*WIDTH] & ((|w_str[2*WIDTH-1:0]) | w_pbody[0]) & ~(&w_pbody);
    w_enc     = {1'b0, w_pbody + {{(WIDTH-2){1'b0}}, w_erup}};
    case (r_mode)
      M_PASS:  w_rni_res = r_opnd;
      M_ZERO:  w_rni_res = '0;
      default: w_rni_res = (r_n == '0) ? '0 : (r_sign ? -w_enc : w_enc);
    endcase
  end

  // Only one source can load per edge: accepts happen in IDLE only.
  assign w_load     = (w_accept & (bus.in_op_i != OP_RNI)) |
                      (((r_state == S_ENCODE) | (r_state == S_HOLD)) & w_free);
  assign w_load_res = (r_state == S_IDLE) ? w_sc_res : w_rni_res;
  assign w_load_tag = (r_state == S_IDLE) ? bus.in_tag_i : r_tag;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_opnd       <= '0;
      r_tag        <= '0;
      r_sign       <= 1'b0;
      r_mode       <= M_CALC;
      r_scale      <= 0;
      r_sig        <= '0;
      r_n          <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
      r_out_nar    <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_valid  <= 1'b1;
        r_out_result <= w_load_res;
        r_out_tag    <= w_load_tag;
        r_out_nar    <= (w_load_res == NAR);
      end else if (bus.out_ready_i) begin
        r_out_valid  <= 1'b0;
      end

      case (r_state)
        S_IDLE: if (w_accept) begin
          r_opnd <= bus.in_operand_i;
          r_tag  <= bus.in_tag_i;
          if (bus.in_op_i == OP_RNI) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_sign  <= r_opnd[WIDTH-1];
          r_scale <= w_scale;
          r_sig   <= {1'b1, w_frac};
          if (r_opnd == '0 || r_opnd == NAR || w_scale >= SBYP) r_mode <= M_PASS;
          else if (w_scale < -1)                                r_mode <= M_ZERO;
          else                                                  r_mode <= M_CALC;
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_n     <= w_n;
          r_state <= S_ENCODE;
        end
        S_ENCODE: r_state <= w_free ? S_IDLE : S_HOLD;
        S_HOLD:   if (w_free) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready_o   = (r_state == S_IDLE) & w_free;
  assign bus.out_valid_o  = r_out_valid;
  assign bus.out_result_o = r_out_result;
  assign bus.out_tag_o    = r_out_tag;
  assign bus.out_nar_o    = r_out_nar;
  assign bus.busy_o       = (r_state != S_IDLE) | r_out_valid;
endmodule

// File: tb/tb_posit_ext_op_sequencer.sv
module tb_posit_ext_op_sequencer;
  localparam int W    = 16;
  localparam int ES   = 1;
  localparam int TW   = 4;
  localparam int MAXI = (1 << (W-1)) - 1;
  localparam logic [W-1:0] NAR = {1'b1, {(W-1){1'b0}}};
  localparam logic [1:0] OP_NEG = 2'b00, OP_ABS = 2'b01, OP_SGN = 2'b10, OP_RNI = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  posit_ext_op_sequencer_if #(.WIDTH(W), .TAG_W(TW)) bus();
  posit_ext_op_sequencer #(.WIDTH(W), .ES(ES), .TAG_W(TW)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: posit values as reals ----------------
  real ptab [0:MAXI];

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real p2r(input logic [W-1:0] x);
    logic [W-1:0] m;
    int run, k, e, i;
    logic b0;
    real f, sc;
    if (x == '0 || x == NAR) return 0.0;
    m = x[W-1] ? -x : x;
    b0 = m[W-2]; run = 0; i = W-2;
    while (i >= 0 && m[i] == b0) begin run++; i--; end
    k = b0 ? run - 1 : -run;
    i--;
    e = 0;
    for (int j = 0; j < ES; j++) begin
      e = e * 2;
      if (i >= 0 && m[i]) e = e + 1;
      i--;
    end
    f = 1.0; sc = 0.5;
    while (i >= 0) begin
      if (m[i]) f = f + sc;
      sc = sc / 2.0; i--;
    end
    f = f * pow2(k * (1 << ES) + e);
    return x[W-1] ? -f : f;
  endfunction

  // nearest positive posit pattern to a > 0, ties to the even pattern, saturating
  function automatic logic [W-1:0] nearest(input real a);
    int lo = 1, hi = MAXI, mid;
    real d1, d2;
    if (a >= ptab[MAXI]) return W'(MAXI);
    if (a <= ptab[1]) return W'(1);
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (ptab[mid] <= a) lo = mid; else hi = mid - 1;
    end
    if (ptab[lo] == a) return W'(lo);
    d1 = a - ptab[lo]; d2 = ptab[lo+1] - a;
    if (d1 < d2) return W'(lo);
    if (d2 < d1) return W'(lo + 1);
    return (lo % 2 == 0) ? W'(lo) : W'(lo + 1);
  endfunction

  function automatic logic [W-1:0] r2p(input real a);
    logic [W-1:0] m;
    if (a == 0.0) return '0;
    m = nearest(a < 0.0 ? -a : a);
    return (a < 0.0) ? -m : m;
  endfunction

  function automatic real rne(input real a);
    real fl = $floor(a);
    real d  = a - fl;
    if (d > 0.5) return fl + 1.0;
    if (d < 0.5) return fl;
    return ($floor(fl / 2.0) * 2.0 == fl) ? fl : fl + 1.0;
  endfunction

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] x);
    real v = p2r(x);
    if (op == OP_NEG) return (x == '0) ? '0 : W'((1 << W) - int'(x));
    if (x == NAR) return NAR;
    case (op)
      OP_ABS:  return r2p(v < 0.0 ? -v : v);
      OP_SGN:  return (v == 0.0) ? '0 : r2p(v < 0.0 ? -1.0 : 1.0);
      default: return r2p(v < 0.0 ? -rne(-v) : rne(v));
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] x,
                       input logic [TW-1:0] t);
    bus.in_valid_i = v; bus.in_op_i = op; bus.in_operand_i = x; bus.in_tag_i = t;
  endtask

  // one request through the idle sequencer with out_ready_i=1
  task automatic run_vec(input string nm, input logic [1:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] exp, input int lat, input logic [TW-1:0] t);
    int cyc = 0;
    bit rdy_low = 1'b1;
    drive(1'b1, op, x, t);
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    while (!bus.in_ready_o && cyc < 20) begin @(negedge clk); cyc++; end
    chk({nm, " accept"}, 32'(bus.in_ready_o), 32'd1);
    step();
    bus.in_valid_i = 1'b0;
    cyc = 1;
    while (!bus.out_valid_o && cyc < 10) begin
      if (bus.in_ready_o) rdy_low = 1'b0;
      step(); cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'(lat));
    chk({nm, " result"}, 32'(bus.out_result_o), 32'(exp));
    chk({nm, " tag"}, 32'(bus.out_tag_o), 32'(t));
    chk({nm, " nar"}, 32'(bus.out_nar_o), 32'(exp == NAR));
    if (lat > 1) chk({nm, " ready low while busy"}, 32'(rdy_low), 32'd1);
    step();
  endtask

  typedef struct {
    string        nm;
    logic [1:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sx[6];
    logic [1:0]   sop[6];
    logic [W-1:0] sexp[6];
    bit seen;
    exp_t e;

    for (int i = 1; i <= MAXI; i++) ptab[i] = p2r(W'(i));
    ptab[0] = 0.0;

    drive(1'b0, OP_NEG, '0, '0);
    bus.out_ready_i = 1'b1;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(bus.out_valid_o), 0);
    chk("reset busy", 32'(bus.busy_o), 0);
    chk("reset result", 32'(bus.out_result_o), 0);
    chk("reset tag", 32'(bus.out_tag_o), 0);
    chk("reset nar", 32'(bus.out_nar_o), 0);
    rst = 1'b0;
    step();
    chk("idle in_ready", 32'(bus.in_ready_o), 1);

    // ---- table-driven vectors ----
    tbl.push_back('{"neg 4000", OP_NEG, 16'h4000, 16'hC000, 1});
    tbl.push_back('{"neg nar",  OP_NEG, 16'h8000, 16'h8000, 1});
    tbl.push_back('{"neg 0",    OP_NEG, 16'h0000, 16'h0000, 1});
    tbl.push_back('{"abs b800", OP_ABS, 16'hB800, 16'h4800, 1});
    tbl.push_back('{"abs nar",  OP_ABS, 16'h8000, 16'h8000, 1});
    tbl.push_back('{"sgn 0",    OP_SGN, 16'h0000, 16'h0000, 1});
    tbl.push_back('{"sgn b800", OP_SGN, 16'hB800, 16'hC000, 1});
    tbl.push_back('{"rni 4800", OP_RNI, 16'h4800, 16'h5000, 4});
    tbl.push_back('{"rni 5400", OP_RNI, 16'h5400, 16'h5000, 4});
    tbl.push_back('{"rni 3000", OP_RNI, 16'h3000, 16'h0000, 4});
    tbl.push_back('{"rni b800", OP_RNI, 16'hB800, 16'hB000, 4});
    tbl.push_back('{"rni nar",  OP_RNI, 16'h8000, 16'h8000, 4});
    tbl.push_back('{"rni 7fff", OP_RNI, 16'h7FFF, 16'h7FFF, 4});
    tbl.push_back('{"rni 0",    OP_RNI, 16'h0000, 16'h0000, 4});
    tbl.push_back('{"rni 3400", OP_RNI, 16'h3400, 16'h4000, 4});
    tbl.push_back('{"rni 2000", OP_RNI, 16'h2000, 16'h0000, 4});
    foreach (tbl[i]) run_vec(tbl[i].nm, tbl[i].op, tbl[i].x, tbl[i].exp, tbl[i].lat, TW'(i));

    // ---- back-to-back single-cycle stream, ends with drain+accept of ABS c000 ----
    sop = '{OP_NEG, OP_NEG, OP_ABS, OP_SGN, OP_SGN, OP_ABS};
    sx  = '{16'h4000, 16'h4800, 16'hB800, 16'h5400, 16'hB800, 16'hC000};
    sexp = '{16'hC000, 16'hB800, 16'h4800, 16'h4000, 16'hC000, 16'h4000};
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, sop[i], sx[i], TW'(i + 3));
      step();
      chk("stream valid", 32'(bus.out_valid_o), 1);
      chk("stream result", 32'(bus.out_result_o), 32'(sexp[i]));
      chk("stream tag", 32'(bus.out_tag_o), 32'(i + 3));
    end
    bus.in_valid_i = 1'b0;
    step();
    chk("stream drained", 32'(bus.out_valid_o), 0);

    // ---- reset in the middle of an RNI ----
    drive(1'b1, OP_RNI, 16'h5400, 4'h5);
    step();
    bus.in_valid_i = 1'b0;
    chk("rni in flight ready", 32'(bus.in_ready_o), 0);
    step();
    rst = 1'b1;
    #1;
    chk("mid-rni reset valid", 32'(bus.out_valid_o), 0);
    chk("mid-rni reset busy", 32'(bus.busy_o), 0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid_o) seen = 1'b1;
      step();
    end
    chk("no stale result", 32'(seen), 0);
    chk("post-reset ready", 32'(bus.in_ready_o), 1);
    chk("post-reset busy", 32'(bus.busy_o), 0);

    // ---- backpressure: RNI behind a pending NEG, then a held RNI result ----
    bus.out_ready_i = 1'b0;
    drive(1'b1, OP_NEG, 16'h4000, 4'h1);
    step();
    drive(1'b1, OP_RNI, 16'h4800, 4'h2);
    for (int i = 0; i < 4; i++) begin
      chk("bp ready low", 32'(bus.in_ready_o), 0);
      chk("bp neg stable", 32'(bus.out_result_o), 32'h0000C000);
      step();
    end
    bus.out_ready_i = 1'b1;
    #1;
    chk("bp ready on drain", 32'(bus.in_ready_o), 1);
    step();
    drive(1'b0, OP_NEG, '0, '0);
    bus.out_ready_i = 1'b0;
    chk("bp neg delivered once", 32'(bus.out_valid_o), 0);
    step(); step();
    chk("bp rni not early", 32'(bus.out_valid_o), 0);
    step();
    chk("bp rni valid", 32'(bus.out_valid_o), 1);
    for (int i = 0; i < 4; i++) begin
      chk("bp rni stable", 32'(bus.out_result_o), 32'h00005000);
      chk("bp rni tag", 32'(bus.out_tag_o), 32'd2);
      chk("bp busy", 32'(bus.busy_o), 1);
      step();
    end
    bus.out_ready_i = 1'b1;
    step();
    chk("bp rni delivered once", 32'(bus.out_valid_o), 0);

    // ---- randomized traffic against the scoreboard ----
    for (int c = 0; c < 600; c++) begin
      logic [W-1:0] x;
      int r = $urandom_range(0, 9);
      if (r == 0)      x = '0;
      else if (r == 1) x = NAR;
      else if (r < 6)  x = W'($urandom_range(16'h2800, 16'h6400)) ^ ($urandom_range(0, 1) ? 16'hFFFF : 16'h0000);
      else             x = W'($urandom);
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), x, TW'($urandom));
      bus.out_ready_i = 1'($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (sb.size() == 0) chk("rand spurious result", 32'(bus.out_valid_o), 0);
        else begin
          e = sb.pop_front();
          chk("rand result", 32'(bus.out_result_o), 32'(e.res));
          chk("rand tag", 32'(bus.out_tag_o), 32'(e.tag));
          chk("rand nar", 32'(bus.out_nar_o), 32'(e.res == NAR));
        end
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        e.res = model(bus.in_op_i, bus.in_operand_i);
        e.tag = bus.in_tag_i;
        sb.push_back(e);
      end
      step();
    end
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_valid_o) begin
        if (sb.size() == 0) chk("drain spurious result", 32'(bus.out_valid_o), 0);
        else begin
          e = sb.pop_front();
          chk("drain result", 32'(bus.out_result_o), 32'(e.res));
          chk("drain tag", 32'(bus.out_tag_o), 32'(e.tag));
        end
      end
      step();
    end
    chk("scoreboard empty", 32'(sb.size()), 0);
    chk("final busy", 32'(bus.busy_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/posit_ext_op_sequencer.md
Name: posit_ext_op_sequencer

Overview:
Sequencing front-end for the posit FPU's extended (non-arithmetic) operations: NEG, ABS, SGN and RNI (round to nearest integer). It accepts tagged requests over a valid/ready handshake and runs single-cycle ops directly. RNI is sequenced through a multi-cycle decode/round/encode FSM. One result register drives a valid/ready output with full backpressure.

Parameters:
WIDTH, 16, posit width in bits (>= 8)
ES, 1, posit exponent field width
TAG_W, 4, request tag width, passed through unchanged

Ports:
clk_i  in  1  clock, rising-edge
rst_i  in  1  asynchronous, active-high reset
in_valid_i  in  1  request valid
in_ready_o  out  1  request accepted when in_valid_i & in_ready_o
in_op_i  in  2  00 NEG, 01 ABS, 10 SGN, 11 RNI
in_operand_i  in  WIDTH  posit operand
in_tag_i  in  TAG_W  request tag
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer ready
out_result_o  out  WIDTH  posit result
out_tag_o  out  TAG_W  tag of the result
out_nar_o  out  1  result is NaR
busy_o  out  1  FSM not IDLE or result pending

Behaviour:
- Reset (async, immediate): state=IDLE; out_valid_o=0, out_result_o=0, out_tag_o=0, out_nar_o=0, busy_o=0. A request in flight is discarded and no result is produced.
- States: IDLE, DECODE, ROUND, ENCODE, HOLD.
- in_ready_o = (state==IDLE) & (!out_valid_o | out_ready_i). It is combinational and carries no dependence on in_valid_i.
- NEG/ABS/SGN are computed on accept. The result registers at that edge, so out_valid_o=1 on the next cycle (latency 1). State stays IDLE, so back-to-back throughput is 1/cycle while out_ready_i=1.
- RNI flow on accept: operand and tag latch -> DECODE -> ROUND -> ENCODE. The result registers on the ENCODE->IDLE edge, so out_valid_o rises 4 cycles after accept. No new request is accepted during DECODE/ROUND/ENCODE.
- HOLD is entered from ENCODE when out_valid_o=1 and out_ready_i=0. The computed result waits in HOLD until the output register frees, then transfers and the FSM returns to IDLE.
- Output register: out_valid_o clears on out_valid_o & out_ready_i unless a new result loads the same edge. While out_valid_o=1 & out_ready_i=0, out_result_o, out_tag_o and out_nar_o are stable.
- NEG: two's-complement negation of the whole word, mod 2^WIDTH. 0 maps to 0 and NaR (1 followed by zeros) maps to NaR.
- ABS: MSB=1 and not NaR -> two's complement; otherwise pass through. NaR passes through.
- SGN: 0 -> 0; NaR -> NaR; negative -> -1 (two's complement of 0100..0 = 1100..0); positive -> 0100..0.
- RNI, DECODE stage: take the two's-complement magnitude when negative. Extract regime k, exponent e and fraction. Scale s = k*2^ES + e. Form a fixed-point magnitude with WIDTH integer bits and WIDTH fraction bits.
- RNI, ROUND stage: round half to even on the integer part.
  - s < -1 -> magnitude 0.
  - s = -1 -> value in [0.5,1): exactly 0.5 -> 0, otherwise 1.
  - s >= WIDTH-ES-3 (no fraction bits remain) -> operand passes unchanged.
- RNI, ENCODE stage: convert the integer to a posit with round-to-nearest-even on truncated bits. Magnitude 0 -> 0 with no sign. Re-apply the sign by two's complement. Saturate to maxpos/-maxpos and never produce NaR from a finite input.
- RNI special cases: NaR -> NaR and 0 -> 0, both still taking the full 4-cycle latency.
- out_nar_o = (out_result_o == 1 followed by zeros).
- busy_o = (state != IDLE) | out_valid_o.
- Simultaneous events: an out_ready_i drain and a new accept in the same cycle are legal. The output reloads with the new single-cycle result and out_valid_o stays 1.
- in_op_i and in_operand_i are sampled only on the accept edge. Changes at other times are ignored.

Test Plan:
- Reset mid-RNI: accept RNI 0x5400, assert rst_i in ROUND -> out_valid_o=0 at once. After release, in_ready_o=1 and busy_o=0, and no stale result ever appears.
- Single-cycle stream with out_ready_i=1 (WIDTH=16, ES=1): NEG 0x4000, NEG 0x4800, ABS 0xB800, SGN 0x5400, SGN 0xB800. One accept per cycle; results in order, 1 cycle later: 0xC000, 0xB800, 0x4800, 0x4000, 0xC000, with tags preserved.
- RNI rounding:
  - 0x4800 (1.5) -> 0x5000
  - 0x5400 (2.5) -> 0x5000 (ties to even)
  - 0x3000 (0.5) -> 0x0000
  - 0xB800 (-1.5) -> 0xB000
  - Each has out_valid_o 4 cycles after accept and in_ready_o=0 during DECODE/ROUND/ENCODE.
- Specials: NEG 0x8000 -> 0x8000 with out_nar_o=1; SGN 0x0000 -> 0x0000; RNI 0x8000 -> 0x8000 with out_nar_o=1; RNI 0x7FFF -> 0x7FFF.
- Backpressure: hold out_ready_i=0 and issue RNI 0x4800 while a NEG result is pending -> the RNI is not accepted until the pending result drains. For a pending RNI result, the FSM reaches HOLD with outputs stable. Raising out_ready_i delivers both in order with no loss or duplication.
- Drain+accept same edge: out_valid_o=1, out_ready_i=1, in_valid_i=1 with ABS 0xC000 -> next cycle out_result_o=0x4000 and out_valid_o stays high.
